appr_mult_pipe: RTL

Pipelined, parametrised signed approximate multiplier with a per-transaction exact/approximate mode and valid/ready handshakes on both sides. Each product is formed in sign-magnitude from truncated partial products plus a single OR-based error-recovery bit; a saturating counter tracks how often error recovery fires. The block replaces the combinational 16-bit approximate multiplier in datapaths that need configurable width and truncation depth, throughput of one product per cycle, and backpressure.

---
 rtl/appr_mult_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/appr_mult_pipe.sv
// Three-stage pipelined signed multiplier with per-item exact/approximate mode.
// Approximate products drop the low K columns and restore one OR-based error-recovery bit.
module appr_mult_pipe #(
  parameter int WIDTH = 16,
  parameter int K     = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_approx,
  output logic               out_er,
  input  logic               clr_count,
  output logic [CNT_W-1:0]   er_count
);

  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [PW-1:0]    ONE_P    = PW'(1);
  localparam logic [PW-1:0]    LOW_MASK = (ONE_P << K) - ONE_P;
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and ready may depend combinationally on out_ready.
  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  assign adv3      = !v3 || out_ready;
  assign adv2      = !v2 || adv3;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v3;

  // Stage 0: operand magnitudes and product sign
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             sign_in;

  assign mag_a   = in_a[WIDTH-1] ? (~in_a + ONE_W) : in_a;
  assign mag_b   = in_b[WIDTH-1] ? (~in_b + ONE_W) : in_b;
  assign sign_in = in_a[WIDTH-1] ^ in_b[WIDTH-1];

  logic [WIDTH-1:0] s1_mag_a, s1_mag_b;
  logic             s1_sign, s1_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      s1_mag_a <= '0;
      s1_mag_b <= '0;
      s1_sign  <= 1'b0;
      s1_mode  <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_mag_a <= mag_a;
        s1_mag_b <= mag_b;
        s1_sign  <= sign_in;
        s1_mode  <= in_mode;
      end
    end
  end

  // Stage 1 -> 2: partial-product accumulation, exact and truncated side by side
  logic [PW-1:0] pp;
  logic [PW-1:0] exact_sum, trunc_sum, low_or;
  logic [PW-1:0] approx_mag, mag_sel;
  logic          er_bit, er_sel;

  always_comb begin
    pp        = '0;
    exact_sum = '0;
    trunc_sum = '0;
    low_or    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pp        = s1_mag_b[i] ? ({{WIDTH{1'b0}}, s1_mag_a} << i) : '0;
      exact_sum = exact_sum + pp;
      trunc_sum = trunc_sum + (pp & ~LOW_MASK);
      low_or    = low_or | (pp & LOW_MASK);
    end
  end

  // Bit K-1 of trunc_sum is always 0, so OR-ing the recovery bit there is lossless.
  assign er_bit     = |low_or;
  assign approx_mag = trunc_sum | ({{(PW-1){1'b0}}, er_bit} << (K - 1));
  assign mag_sel    = s1_mode ? approx_mag : exact_sum;
  assign er_sel     = s1_mode & er_bit;

  logic [PW-1:0] s2_mag;
  logic          s2_er, s2_sign, s2_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2      <= 1'b0;
      s2_mag  <= '0;
      s2_er   <= 1'b0;
      s2_sign <= 1'b0;
      s2_mode <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        s2_mag  <= mag_sel;
        s2_er   <= er_sel;
        s2_sign <= s1_sign;
        s2_mode <= s1_mode;
      end
    end
  end

  // Stage 2 -> 3: sign application; a zero magnitude negates to zero naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3         <= 1'b0;
      out_p      <= '0;
      out_er     <= 1'b0;
      out_approx <= 1'b0;
    end else if (adv3) begin
      v3 <= v2;
      if (v2) begin
        out_p      <= s2_sign ? (~s2_mag + ONE_P) : s2_mag;
        out_er     <= s2_er;
        out_approx <= s2_mode;
      end
    end
  end

  logic count_hit;
  assign count_hit = out_valid && out_ready && out_approx && out_er;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      er_count <= '0;
    end else if (clr_count) begin
      er_count <= '0;
    end else if (count_hit && (er_count != {CNT_W{1'b1}})) begin
      er_count <= er_count + ONE_C;
    end
  end

endmodule
